// File: rtl/pc_seq_ctrl_pkg.sv
// Shared encodings and defaults for the fetch-stage PC sequencer.
package pc_seq_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned CNT_W  = 16;

    // PC mux select encodings
    typedef enum logic [CTRL_W-1:0] {
        NPC_PC4   = 3'b000,
        NPC_BR    = 3'b001,
        NPC_JR    = 3'b010,
        NPC_J_JAL = 3'b011,
        NPC_JI    = 3'b100
    } npc_ctrl_e;

    // Sequencer states: sequential fetch, or fetching a delay slot
    typedef enum logic {
        ST_SEQ = 1'b0,
        ST_DS  = 1'b1
    } state_e;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [XLEN-1:0] PC_MIN_DEF   = 32'h0000_3000;
    localparam logic [XLEN-1:0] PC_MAX_DEF   = 32'h0000_4FFC;

    // A fetch target is illegal if misaligned or outside [lo, hi]
    function automatic logic addr_illegal(input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] lo,
                                          input logic [XLEN-1:0] hi);
        return (a[1:0] != 2'b00) || (a < lo) || (a > hi);
    endfunction

endpackage

// File: rtl/pc_seq_ctrl.sv
// Fetch-stage PC sequencer: PC register, mux select, delay-slot tracking,
// redirect counting and illegal-target detection.
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_MIN   = PC_MIN_DEF,
    parameter logic [31:0] PC_MAX   = PC_MAX_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                d_branch,
    input  logic                d_br_taken,
    input  logic                d_jr,
    input  logic                d_j_jal,
    input  logic                exc_req,
    input  logic [XLEN-1:0]     npc_in,
    output logic [CTRL_W-1:0]   npc_ctrl,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc4,
    output logic                f_in_ds,
    output logic                flush,
    output logic                addr_err,
    output logic [CNT_W-1:0]    redir_cnt
);

    state_e             state_q, state_d;
    npc_ctrl_e          npc_sel;
    logic               adv;
    logic               is_ctrl;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    // An exception redirect always advances, even through a stall
    assign adv     = !stall || exc_req;
    assign is_ctrl = d_branch || d_jr || d_j_jal;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SEQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a control instruction opens a delay slot; the slot closes on the next advance
    always_comb begin
        state_d = state_q;
        if (exc_req) begin
            state_d = ST_SEQ;
        end else if (adv) begin
            case (state_q)
                ST_SEQ:  state_d = is_ctrl ? ST_DS : ST_SEQ;
                ST_DS:   state_d = ST_SEQ;
                default: state_d = ST_SEQ;
            endcase
        end
    end

    // Outputs: prioritised mux select, flush strobe, delay-slot flag
    always_comb begin
        npc_sel = NPC_PC4;
        flush   = 1'b0;
        f_in_ds = (state_q == ST_DS);
        if (!reset) begin
            if (exc_req) begin
                npc_sel = NPC_JI;
                flush   = 1'b1;
            end else if (stall) begin
                npc_sel = NPC_PC4;
            end else if (d_jr) begin
                npc_sel = NPC_JR;
            end else if (d_j_jal) begin
                npc_sel = NPC_J_JAL;
            end else if (d_branch && d_br_taken) begin
                npc_sel = NPC_BR;
            end
        end
    end

    // Datapath next values: PC load, saturating redirect count, sticky error
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (adv) begin
            pc_d = npc_in;
            if ((npc_sel != NPC_PC4) && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (addr_illegal(npc_in, PC_MIN, PC_MAX)) begin
                err_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign npc_ctrl  = npc_sel;
    assign pc        = pc_q;
    assign pc4       = pc_q + XLEN'(4);
    assign addr_err  = err_q;
    assign redir_cnt = cnt_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: priority table plus directed sequences.
module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset, stall, d_branch, d_br_taken, d_jr, d_j_jal, exc_req;
    logic [31:0] npc_in;
    logic [2:0]  npc_ctrl;
    logic [31:0] pc, pc4;
    logic        f_in_ds, flush, addr_err;
    logic [15:0] redir_cnt;

    int total  = 0;
    int passed = 0;

    pc_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .d_branch   (d_branch),
        .d_br_taken (d_br_taken),
        .d_jr       (d_jr),
        .d_j_jal    (d_j_jal),
        .exc_req    (exc_req),
        .npc_in     (npc_in),
        .npc_ctrl   (npc_ctrl),
        .pc         (pc),
        .pc4        (pc4),
        .f_in_ds    (f_in_ds),
        .flush      (flush),
        .addr_err   (addr_err),
        .redir_cnt  (redir_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, st, br, tk, jr, jj, ex;
        logic [2:0] e_ctrl;
        logic       e_flush;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic rst, st, br, tk, jr, jj, ex, input logic [31:0] npc);
        reset = rst; stall = st; d_branch = br; d_br_taken = tk;
        d_jr = jr; d_j_jal = jj; exc_req = ex; npc_in = npc;
    endtask

    // Drive one cycle, check comb outputs before the edge and registered state after it
    task automatic step(input string nm, input logic rst, st, br, tk, jr, jj, ex,
                        input logic [31:0] npc, input logic [2:0] e_ctrl, input logic e_flush,
                        input logic [31:0] e_pc, input logic e_ds, input logic [15:0] e_cnt,
                        input logic e_err);
        drive(rst, st, br, tk, jr, jj, ex, npc);
        #1;
        chk({nm, ".npc_ctrl"}, 32'(npc_ctrl), 32'(e_ctrl));
        chk({nm, ".flush"}, 32'(flush), 32'(e_flush));
        @(posedge clk); #1;
        chk({nm, ".pc"}, pc, e_pc);
        chk({nm, ".pc4"}, pc4, e_pc + 32'd4);
        chk({nm, ".f_in_ds"}, 32'(f_in_ds), 32'(e_ds));
        chk({nm, ".redir_cnt"}, 32'(redir_cnt), 32'(e_cnt));
        chk({nm, ".addr_err"}, 32'(addr_err), 32'(e_err));
    endtask

    task automatic do_reset(input string nm);
        step(nm, 1, 1, 0, 0, 0, 0, 1, 32'h4000, 3'b000, 0, 32'h3000, 0, 16'h0, 0);
    endtask

    initial begin
        //            rst st br tk jr jj ex  ctrl    flush
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 3'b000, 0};
        tbl[1]  = '{0, 0, 1, 1, 0, 0, 0, 3'b001, 0};
        tbl[2]  = '{0, 0, 1, 0, 0, 0, 0, 3'b000, 0};
        tbl[3]  = '{0, 0, 0, 1, 0, 0, 0, 3'b000, 0};
        tbl[4]  = '{0, 0, 0, 0, 1, 0, 0, 3'b010, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 1, 0, 3'b011, 0};
        tbl[6]  = '{0, 0, 0, 0, 1, 1, 0, 3'b010, 0};
        tbl[7]  = '{0, 0, 1, 1, 0, 1, 0, 3'b011, 0};
        tbl[8]  = '{0, 0, 1, 1, 1, 0, 0, 3'b010, 0};
        tbl[9]  = '{0, 1, 0, 0, 1, 0, 0, 3'b000, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 3'b100, 1};
        tbl[11] = '{0, 1, 0, 0, 1, 0, 1, 3'b100, 1};
        tbl[12] = '{1, 1, 0, 0, 0, 0, 1, 3'b000, 0};
        tbl[13] = '{1, 0, 0, 0, 1, 0, 0, 3'b000, 0};

        drive(1, 0, 0, 0, 0, 0, 0, 32'h3000);
        @(posedge clk); #1;

        // Combinational mux-select priority table
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].st, tbl[i].br, tbl[i].tk, tbl[i].jr, tbl[i].jj,
                  tbl[i].ex, 32'h3000);
            #1;
            chk($sformatf("tbl%0d.npc_ctrl", i), 32'(npc_ctrl), 32'(tbl[i].e_ctrl));
            chk($sformatf("tbl%0d.flush", i), 32'(flush), 32'(tbl[i].e_flush));
        end

        // Reset overriding stall and exc_req, then free-running fetch
        do_reset("rst0");
        step("seq1", 0, 0, 0, 0, 0, 0, 0, 32'h3004, 3'b000, 0, 32'h3004, 0, 16'd0, 0);
        step("seq2", 0, 0, 0, 0, 0, 0, 0, 32'h3008, 3'b000, 0, 32'h3008, 0, 16'd0, 0);
        // Taken branch at 3008 opens a delay slot
        step("br",   0, 0, 1, 1, 0, 0, 0, 32'h3040, 3'b001, 0, 32'h3040, 1, 16'd1, 0);
        step("ds1",  0, 0, 0, 0, 0, 0, 0, 32'h3044, 3'b000, 0, 32'h3044, 0, 16'd1, 0);
        // jr held by stall for two cycles, then released
        step("jrst1", 0, 1, 0, 0, 1, 0, 0, 32'h3100, 3'b000, 0, 32'h3044, 0, 16'd1, 0);
        step("jrst2", 0, 1, 0, 0, 1, 0, 0, 32'h3100, 3'b000, 0, 32'h3044, 0, 16'd1, 0);
        step("jr",    0, 0, 0, 0, 1, 0, 0, 32'h3100, 3'b010, 0, 32'h3100, 1, 16'd2, 0);
        // Stall inside a delay slot holds the slot
        step("dsst",  0, 1, 0, 0, 0, 0, 0, 32'h3104, 3'b000, 0, 32'h3100, 1, 16'd2, 0);
        // Exception in a delay slot overrides stall, flushes, returns to SEQ
        step("exc",   0, 1, 0, 0, 0, 0, 1, 32'h4180, 3'b100, 1, 32'h4180, 0, 16'd3, 0);
        // Jump, then a not-taken branch in its slot does not re-enter DS
        step("jal",   0, 0, 0, 0, 0, 1, 0, 32'h3200, 3'b011, 0, 32'h3200, 1, 16'd4, 0);
        step("dsbr",  0, 0, 1, 0, 0, 0, 0, 32'h3204, 3'b000, 0, 32'h3204, 0, 16'd4, 0);
        // Not-taken branch still opens a delay slot without counting
        step("brnt",  0, 0, 1, 0, 0, 0, 0, 32'h3208, 3'b000, 0, 32'h3208, 1, 16'd4, 0);
        step("dsj",   0, 0, 0, 0, 0, 1, 0, 32'h3300, 3'b011, 0, 32'h3300, 0, 16'd5, 0);
        // Exception wins over a concurrent control instruction
        step("excjr", 0, 0, 0, 0, 1, 0, 1, 32'h3400, 3'b100, 1, 32'h3400, 0, 16'd6, 0);
        // Misaligned target sets a sticky error, pc still loads
        step("mis",   0, 0, 0, 0, 0, 0, 0, 32'h3002, 3'b000, 0, 32'h3002, 0, 16'd6, 1);
        step("stick", 0, 0, 0, 0, 0, 0, 0, 32'h3010, 3'b000, 0, 32'h3010, 0, 16'd6, 1);
        step("stall_err", 0, 1, 0, 0, 0, 0, 0, 32'h3014, 3'b000, 0, 32'h3010, 0, 16'd6, 1);
        do_reset("rst1");

        // Range boundaries
        step("hi_ok", 0, 0, 0, 0, 0, 0, 0, 32'h4FFC, 3'b000, 0, 32'h4FFC, 0, 16'd0, 0);
        step("lo_ok", 0, 0, 0, 0, 0, 0, 0, 32'h3000, 3'b000, 0, 32'h3000, 0, 16'd0, 0);
        step("hi_bad", 0, 0, 0, 0, 0, 0, 0, 32'h5000, 3'b000, 0, 32'h5000, 0, 16'd0, 1);
        do_reset("rst2");
        step("lo_bad", 0, 0, 0, 0, 0, 0, 0, 32'h2FFC, 3'b000, 0, 32'h2FFC, 0, 16'd0, 1);
        do_reset("rst3");

        // Reset in the middle of a delay slot discards it
        step("br2",   0, 0, 1, 1, 0, 0, 0, 32'h3040, 3'b001, 0, 32'h3040, 1, 16'd1, 0);
        do_reset("rst_ds");

        // Redirect counter saturation: 65533 branches unchecked, then watch the top
        drive(0, 0, 1, 1, 0, 0, 0, 32'h3000);
        repeat (65533) @(posedge clk);
        #1;
        step("sat_m1", 0, 0, 1, 1, 0, 0, 0, 32'h3000, 3'b001, 0, 32'h3000, 0, 16'hFFFE, 0);
        step("sat",    0, 0, 1, 1, 0, 0, 0, 32'h3000, 3'b001, 0, 32'h3000, 1, 16'hFFFF, 0);
        step("sat_p1", 0, 0, 1, 1, 0, 0, 0, 32'h3000, 3'b001, 0, 32'h3000, 0, 16'hFFFF, 0);
        do_reset("rst4");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter PC_MIN, default 32'h0000_3000, lowest legal fetch address.
REQ-003 Parameter PC_MAX, default 32'h0000_4FFC, highest legal fetch address.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 stall  in  1  hazard unit freeze of F/D.
REQ-008 d_branch  in  1  D-stage instruction is a conditional branch.
REQ-009 d_br_taken  in  1  D-stage branch condition true; valid only with d_branch.
REQ-010 d_jr  in  1  D-stage jr/jalr.
REQ-011 d_j_jal  in  1  D-stage j/jal.
REQ-012 exc_req  in  1  later-stage redirect to the exception vector (JI target).
REQ-013 npc_in  in  32  selected next PC returned from the PC mux.
REQ-014 npc_ctrl  out  3  mux select: 000 PC4, 001 BR, 010 JR, 011 J_JAL, 100 JI.
REQ-015 pc  out  32  current fetch PC.
REQ-016 pc4  out  32  pc + 4, fed to the mux PC4 input.
REQ-017 f_in_ds  out  1  instruction at pc is a delay slot.
REQ-018 flush  out  1  one-cycle F/D flush strobe.
REQ-019 addr_err  out  1  sticky illegal-target flag.
REQ-020 redir_cnt  out  16  count of committed non-PC4 redirects.

Function
REQ-021 npc_ctrl is combinational with priority: exc_req -> 100; else stall -> 000; else d_jr -> 010; else d_j_jal -> 011; else d_branch & d_br_taken -> 001; else 000.
REQ-022 More than one of d_branch/d_jr/d_j_jal high is a protocol error; priority of REQ-021 resolves it.
REQ-023 pc4 = pc + 32'd4, modulo 2^32, combinational.
REQ-024 Each rising edge, unless reset or (stall & !exc_req), pc loads npc_in (one-cycle latency from npc_ctrl to pc).
REQ-025 stall & !exc_req: pc, state, f_in_ds and redir_cnt hold.
REQ-026 FSM states SEQ and DS; f_in_ds = (state == DS).
REQ-027 SEQ -> DS on an accepted advance (REQ-024) with d_branch|d_jr|d_j_jal, taken or not, and !exc_req.
REQ-028 DS -> SEQ on any accepted advance without exc_req; a control instruction in a delay slot does not re-enter DS (stays SEQ, UB for software).
REQ-029 exc_req: forces state SEQ, pc <= npc_in, flush = 1 for that cycle, overriding stall.
REQ-030 redir_cnt increments by 1 on each accepted advance with npc_ctrl != 000; saturates at 16'hFFFF.
REQ-031 addr_err sets on an accepted advance where npc_in[1:0] != 0 or npc_in < PC_MIN or npc_in > PC_MAX; pc still loads npc_in; cleared only by reset.

Reset
REQ-032 Reset: pc = RESET_PC, state = SEQ, f_in_ds = 0, flush = 0, addr_err = 0, redir_cnt = 0; npc_ctrl = 000 while reset high.
REQ-033 Reset overrides exc_req and stall in the same cycle; mid-delay-slot reset discards DS.

Structure
REQ-034 Shared package holds npc_ctrl encodings (NPC_PC4..NPC_JI), state encodings and RESET_PC default.
REQ-035 No sub-module; the PC mux stays a separate instance in the fetch stage.

Verification
REQ-036 Reset, 3 free cycles, npc_in = pc4 -> pc 3000, 3004, 3008, 300C; npc_ctrl 000; f_in_ds 0.
REQ-037 d_branch=1, d_br_taken=1, npc_in=3040 at pc 3008 -> npc_ctrl 001; next pc 3040, f_in_ds 1, redir_cnt 1; following cycle f_in_ds 0.
REQ-038 d_jr=1 with stall=1 for 2 cycles -> npc_ctrl 000, pc held; stall drops -> npc_ctrl 010, pc loads npc_in, f_in_ds 1.
REQ-039 exc_req=1, stall=1, npc_in=4180 while in DS -> npc_ctrl 100, flush 1, pc 4180, state SEQ.
REQ-040 npc_in = 3002 on advance -> addr_err 1 next cycle, persists until reset.
REQ-041 redir_cnt preloaded to FFFF via 65535 taken branches -> one more stays FFFF.
